// File: rtl/agex_stage_pkg.sv
// agex_stage_pkg: shared types for the AGEX stage.
//   op_t          - decoded operation carried in op_I
//   de_latch_t    - DE->AGEX pipeline latch
//   agex_latch_t  - AGEX->MEM pipeline latch
//   widths of the latches and the AGEX feedback buses
package agex_stage_pkg;

    typedef enum logic [5:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI,
        OP_SLTIU, OP_SLLI, OP_SRLI, OP_SRAI, OP_LUI, OP_AUIPC, OP_LW, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR,
        OP_MUL
    } op_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] pcplus;
        op_t         op_I;
        logic [31:0] inst_count;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        wr_reg;
        logic [4:0]  shamt;
        logic [31:0] canary;
    } de_latch_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        op_t         op_I;
        logic [31:0] inst_count;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        wr_reg;
        logic [31:0] canary;
    } agex_latch_t;

    localparam int DE_latch_WIDTH   = $bits(de_latch_t);
    localparam int AGEX_latch_WIDTH = $bits(agex_latch_t);
    localparam int AGEX_TO_FE_WIDTH = 33;  // {br_redirect, br_target}
    localparam int AGEX_TO_DE_WIDTH = 7;   // {stall_cmd, dest_regno, dest_wr}

endpackage

// File: rtl/agex_stage_if.sv
// agex_stage_if: bus bundle around the AGEX stage.
//   from_DE_latch   - decoded instruction into AGEX
//   from_AGEX_to_FE - {br_redirect, br_target}
//   from_AGEX_to_DE - {stall_cmd, dest_regno, dest_wr}
//   AGEX_latch_out  - registered AGEX result latch
// master = upstream/downstream pipeline side, slave = the AGEX stage.
interface agex_stage_if;

    agex_stage_pkg::de_latch_t                                 from_DE_latch;
    logic [agex_stage_pkg::AGEX_TO_FE_WIDTH-1:0] from_AGEX_to_FE;
    logic [agex_stage_pkg::AGEX_TO_DE_WIDTH-1:0] from_AGEX_to_DE;
    agex_stage_pkg::agex_latch_t                               AGEX_latch_out;

    modport master (output from_DE_latch,
                    input  from_AGEX_to_FE, from_AGEX_to_DE, AGEX_latch_out);
    modport slave  (input  from_DE_latch,
                    output from_AGEX_to_FE, from_AGEX_to_DE, AGEX_latch_out);

endinterface

// File: rtl/agex_mul.sv
// agex_mul: iterative 32x32 -> low-32 multiplier, 32/MUL_STEPS bits per step.
//   clk, reset  - clock, synchronous active-high reset
//   i_start     - valid MUL accepted while idle; step 0 is folded into this edge
//   i_rs1/i_rs2 - operands sampled at i_start
//   o_busy      - a sequence is in flight
//   o_done      - final step cycle; o_result is valid this cycle
//   o_result    - low 32 bits of the product (combinational in the final step)
module agex_mul #(
    parameter int MUL_STEPS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);
    localparam int CW = 32 / MUL_STEPS;
    localparam int SW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [SW-1:0] LAST  = SW'(MUL_STEPS - 1);
    localparam logic [31:0]   CMASK = 32'((64'd1 << CW) - 64'd1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        r_state, w_state_n;
    logic [31:0]   r_acc, w_acc_n, r_rs1, w_rs1_n, r_rs2, w_rs2_n;
    logic [SW-1:0] r_step, w_step_n;
    logic [5:0]    w_sh;
    logic [31:0]   w_chunk, w_pp, w_sum;

    // Only the low 32 bits are kept, so shifted partials simply truncate.
    assign w_sh     = 6'(int'(r_step) * CW);
    assign w_chunk  = (r_rs2 >> w_sh) & CMASK;
    assign w_pp     = (r_rs1 * w_chunk) << w_sh;
    assign w_sum    = r_acc + w_pp;
    assign o_busy   = (r_state == S_BUSY);
    assign o_result = w_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_step  <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
        end else begin
            r_state <= w_state_n;
            r_acc   <= w_acc_n;
            r_step  <= w_step_n;
            r_rs1   <= w_rs1_n;
            r_rs2   <= w_rs2_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_acc_n   = r_acc;
        w_step_n  = r_step;
        w_rs1_n   = r_rs1;
        w_rs2_n   = r_rs2;
        o_done    = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) begin
                w_state_n = S_BUSY;
                w_acc_n   = i_rs1 * (i_rs2 & CMASK);
                w_step_n  = SW'(1);
                w_rs1_n   = i_rs1;
                w_rs2_n   = i_rs2;
            end
            S_BUSY: if (r_step == LAST) begin
                o_done    = 1'b1;
                w_state_n = S_IDLE;
                w_acc_n   = '0;
                w_step_n  = '0;
            end else begin
                w_acc_n   = w_sum;
                w_step_n  = r_step + SW'(1);
            end
            default: w_state_n = S_IDLE;
        endcase
    end

endmodule

// File: rtl/agex_stage.sv
// agex_stage: execute / address-generation stage.
//   clk, reset - clock, synchronous active-high reset
//   bus        - agex_stage_if.slave: DE latch in, FE/DE feedback and
//                AGEX latch out
// ALU, load/store address and branches finish in one cycle; MUL with
// MUL_STEPS > 1 runs in agex_mul while DE is stalled.
module agex_stage
    import agex_stage_pkg::*;
#(
    parameter int MUL_STEPS = 4
) (
    input  logic         clk,
    input  logic         reset,
    agex_stage_if.slave  bus
);
    de_latch_t   w_in;
    agex_latch_t r_latch, r_hold, w_alu_out, w_mul_out;
    logic [31:0] w_a, w_b, w_res, w_tgt, w_mul_res;
    logic        w_busy, w_done, w_in_valid, w_mul_start, w_taken;
    logic        w_redirect, w_stall, w_dest_wr;
    logic [4:0]  w_dest_regno;

    assign w_in = bus.from_DE_latch;
    assign w_a  = w_in.rs1_val;
    assign w_b  = w_in.rs2_val;

    // While the multiplier is busy the (held) input is ignored.
    assign w_in_valid  = (|w_in.inst) && !w_busy;
    assign w_mul_start = w_in_valid && (w_in.op_I == OP_MUL) && (MUL_STEPS > 1);

    always_comb begin
        w_res   = '0;
        w_taken = 1'b0;
        w_tgt   = w_in.PC + w_in.imm;
        case (w_in.op_I)
            OP_ADD:   w_res = w_a + w_b;
            OP_SUB:   w_res = w_a - w_b;
            OP_AND:   w_res = w_a & w_b;
            OP_OR:    w_res = w_a | w_b;
            OP_XOR:   w_res = w_a ^ w_b;
            OP_SLT:   w_res = {31'b0, $signed(w_a) < $signed(w_b)};
            OP_SLTU:  w_res = {31'b0, w_a < w_b};
            OP_SLL:   w_res = w_a << w_b[4:0];
            OP_SRL:   w_res = w_a >> w_b[4:0];
            OP_SRA:   w_res = 32'($signed(w_a) >>> w_b[4:0]);
            OP_ADDI,
            OP_LW,
            OP_SW:    w_res = w_a + w_in.imm;
            OP_ANDI:  w_res = w_a & w_in.imm;
            OP_ORI:   w_res = w_a | w_in.imm;
            OP_XORI:  w_res = w_a ^ w_in.imm;
            OP_SLTI:  w_res = {31'b0, $signed(w_a) < $signed(w_in.imm)};
            OP_SLTIU: w_res = {31'b0, w_a < w_in.imm};
            OP_SLLI:  w_res = w_a << w_in.shamt;
            OP_SRLI:  w_res = w_a >> w_in.shamt;
            OP_SRAI:  w_res = 32'($signed(w_a) >>> w_in.shamt);
            OP_LUI:   w_res = w_in.imm;
            OP_AUIPC: w_res = w_in.PC + w_in.imm;
            OP_BEQ:   w_taken = (w_a == w_b);
            OP_BNE:   w_taken = (w_a != w_b);
            OP_BLT:   w_taken = ($signed(w_a) <  $signed(w_b));
            OP_BGE:   w_taken = ($signed(w_a) >= $signed(w_b));
            OP_BLTU:  w_taken = (w_a <  w_b);
            OP_BGEU:  w_taken = (w_a >= w_b);
            OP_JAL:   begin w_taken = 1'b1; w_res = w_in.pcplus; end
            OP_JALR:  begin
                w_taken = 1'b1;
                w_tgt   = (w_a + w_in.imm) & ~32'd1;
                w_res   = w_in.pcplus;
            end
            OP_MUL:   if (MUL_STEPS == 1) w_res = w_a * w_b;
            default:  ;
        endcase
    end

    always_comb begin
        w_alu_out            = '0;
        w_alu_out.inst       = w_in.inst;
        w_alu_out.PC         = w_in.PC;
        w_alu_out.op_I       = w_in.op_I;
        w_alu_out.inst_count = w_in.inst_count;
        w_alu_out.result     = w_res;
        w_alu_out.store_data = (w_in.op_I == OP_SW) ? w_b : 32'h0;
        w_alu_out.rd         = w_in.rd;
        w_alu_out.wr_reg     = w_in.wr_reg;
        w_alu_out.canary     = w_in.canary;
        w_mul_out            = r_hold;
        w_mul_out.result     = w_mul_res;
    end

    agex_mul #(.MUL_STEPS(MUL_STEPS)) u_mul (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_mul_start),
        .i_rs1    (w_a),
        .i_rs2    (w_b),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_result (w_mul_res)
    );

    // r_hold keeps the MUL's metadata so the retiring latch matches the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_latch <= '0;
            r_hold  <= '0;
        end else begin
            if (w_mul_start)
                r_hold <= w_alu_out;
            if (w_done)
                r_latch <= w_mul_out;
            else if (w_in_valid && !w_mul_start)
                r_latch <= w_alu_out;
            else
                r_latch <= '0;
        end
    end

    // Stall drops in the final step so DE advances on the retiring edge.
    assign w_redirect   = !reset && w_in_valid && w_taken;
    assign w_stall      = !reset && (w_mul_start || (w_busy && !w_done));
    assign w_dest_regno = w_busy ? r_hold.rd : w_in.rd;
    assign w_dest_wr    = !reset && (w_busy ? r_hold.wr_reg : (w_in_valid && w_in.wr_reg));

    assign bus.from_AGEX_to_FE = {w_redirect, w_redirect ? w_tgt : 32'h0};
    assign bus.from_AGEX_to_DE = {w_stall, w_dest_regno, w_dest_wr};
    assign bus.AGEX_latch_out  = r_latch;

endmodule

// File: tb/tb_agex_stage.sv
module tb_agex_stage;
    import agex_stage_pkg::*;

    localparam int STEPS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    agex_latch_t sb[$];

    agex_stage_if bus();

    agex_stage #(.MUL_STEPS(STEPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    function automatic de_latch_t mk(op_t op, logic [31:0] rs1, logic [31:0] rs2,
                                     logic [31:0] imm, logic [4:0] sh, logic wr);
        de_latch_t d;
        d            = '0;
        d.inst       = {26'h0AB, op};
        d.PC         = 32'h100;
        d.pcplus     = 32'h104;
        d.op_I       = op;
        d.inst_count = 32'd7;
        d.rs1_val    = rs1;
        d.rs2_val    = rs2;
        d.rd         = 5'd5;
        d.imm        = imm;
        d.wr_reg     = wr;
        d.shamt      = sh;
        d.canary     = 32'hC0FFEE00;
        return d;
    endfunction

    function automatic agex_latch_t ex(de_latch_t d, logic [31:0] res, logic [31:0] sd);
        agex_latch_t e;
        e.inst       = d.inst;
        e.PC         = d.PC;
        e.op_I       = d.op_I;
        e.inst_count = d.inst_count;
        e.result     = res;
        e.store_data = sd;
        e.rd         = d.rd;
        e.wr_reg     = d.wr_reg;
        e.canary     = d.canary;
        return e;
    endfunction

    task automatic test_reset();
        agex_latch_t e;
        reset = 1'b1;
        @(negedge clk);
        bus.from_DE_latch = mk(OP_JAL, 0, 0, 32'h40, 0, 1);
        sb.push_back('0);
        #1;
        n_checks++;
        if (bus.from_AGEX_to_FE !== 33'h0) begin
            n_fail++; $display("FAIL reset_fe: got %h expected 0", bus.from_AGEX_to_FE);
        end
        n_checks++;
        if (bus.from_AGEX_to_DE[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_dest_wr: got %b expected 0", bus.from_AGEX_to_DE[0]);
        end
        @(negedge clk);
        bus.from_DE_latch = mk(OP_MUL, 3, 4, 0, 0, 1);
        #1;
        n_checks++;
        if (bus.from_AGEX_to_DE[6] !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.from_AGEX_to_DE[6]);
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.AGEX_latch_out !== e) begin
            n_fail++; $display("FAIL reset_latch: got %h expected %h", bus.AGEX_latch_out, e);
        end
        @(negedge clk);
        bus.from_DE_latch = '0;
        reset = 1'b0;
    endtask

    task automatic test_alu();
        de_latch_t   t[12];
        logic [31:0] r[12];
        logic [31:0] sd;
        agex_latch_t e;
        t[0]  = mk(OP_ADDI,  32'hFFFFFFFF, 0, 32'h1, 0, 1);          r[0]  = 32'h0;
        t[1]  = mk(OP_SUB,   32'h5, 32'h7, 0, 0, 1);                 r[1]  = 32'hFFFFFFFE;
        t[2]  = mk(OP_SLT,   32'hFFFFFFFF, 32'h0, 0, 0, 1);          r[2]  = 32'h1;
        t[3]  = mk(OP_SLTU,  32'hFFFFFFFF, 32'h0, 0, 0, 1);          r[3]  = 32'h0;
        t[4]  = mk(OP_SRA,   32'h80000000, 32'h24, 0, 0, 1);         r[4]  = 32'hF8000000;
        t[5]  = mk(OP_SLLI,  32'h1, 0, 0, 5'd31, 1);                 r[5]  = 32'h80000000;
        t[6]  = mk(OP_LUI,   0, 0, 32'h12345000, 0, 1);              r[6]  = 32'h12345000;
        t[7]  = mk(OP_AUIPC, 0, 0, 32'h1000, 0, 1);                  r[7]  = 32'h1100;
        t[8]  = mk(OP_SW,    32'h1000, 32'hDEADBEEF, 32'h8, 0, 0);   r[8]  = 32'h1008;
        t[9]  = mk(OP_XORI,  32'hFF00FF00, 0, 32'h0F0F0F0F, 0, 1);   r[9]  = 32'hF00FF00F;
        t[10] = mk(OP_SRLI,  32'h80000000, 0, 0, 5'd4, 1);           r[10] = 32'h08000000;
        t[11] = mk(OP_SLTIU, 32'h3, 0, 32'hFFFFFFFF, 0, 1);          r[11] = 32'h1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.from_DE_latch = t[i];
            sd = (t[i].op_I == OP_SW) ? t[i].rs2_val : 32'h0;
            sb.push_back(ex(t[i], r[i], sd));
            #1;
            n_checks++;
            if (bus.from_AGEX_to_DE !== {1'b0, 5'd5, t[i].wr_reg}) begin
                n_fail++; $display("FAIL alu_dest[%0d]: got %h expected %h", i,
                                   bus.from_AGEX_to_DE, {1'b0, 5'd5, t[i].wr_reg});
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (bus.AGEX_latch_out !== e) begin
                n_fail++; $display("FAIL alu_latch[%0d]: got %h expected %h", i, bus.AGEX_latch_out, e);
            end
        end
    endtask

    task automatic test_branch();
        de_latch_t   d;
        agex_latch_t e;
        @(negedge clk);
        bus.from_DE_latch = mk(OP_BLT, 32'hFFFFFFFF, 32'h0, 32'h20, 0, 0);
        #1;
        n_checks++;
        if (bus.from_AGEX_to_FE !== {1'b1, 32'h120}) begin
            n_fail++; $display("FAIL blt_fe: got %h expected %h", bus.from_AGEX_to_FE, {1'b1, 32'h120});
        end
        @(negedge clk);
        bus.from_DE_latch = mk(OP_BLTU, 32'hFFFFFFFF, 32'h0, 32'h20, 0, 0);
        #1;
        n_checks++;
        if (bus.from_AGEX_to_FE !== 33'h0) begin
            n_fail++; $display("FAIL bltu_fe: got %h expected 0", bus.from_AGEX_to_FE);
        end
        @(negedge clk);
        d = mk(OP_JALR, 32'h203, 0, 32'h0, 0, 1);
        d.pcplus = 32'h44;
        bus.from_DE_latch = d;
        sb.push_back(ex(d, 32'h44, 32'h0));
        #1;
        n_checks++;
        if (bus.from_AGEX_to_FE !== {1'b1, 32'h202}) begin
            n_fail++; $display("FAIL jalr_fe: got %h expected %h", bus.from_AGEX_to_FE, {1'b1, 32'h202});
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.AGEX_latch_out !== e) begin
            n_fail++; $display("FAIL jalr_latch: got %h expected %h", bus.AGEX_latch_out, e);
        end
        // bubble: nothing redirects, stalls or writes
        @(negedge clk);
        bus.from_DE_latch = '0;
        sb.push_back('0);
        #1;
        n_checks++;
        if (bus.from_AGEX_to_FE !== 33'h0 || bus.from_AGEX_to_DE !== 7'h0) begin
            n_fail++; $display("FAIL bubble_fb: got fe=%h de=%h expected 0/0",
                               bus.from_AGEX_to_FE, bus.from_AGEX_to_DE);
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.AGEX_latch_out !== e) begin
            n_fail++; $display("FAIL bubble_latch: got %h expected %h", bus.AGEX_latch_out, e);
        end
    endtask

    task automatic test_back_to_back_mul();
        logic [31:0] a[2], b[2];
        de_latch_t   d;
        agex_latch_t e;
        logic        st;
        a[0] = 32'h12345678; b[0] = 32'h9ABCDEF0;
        a[1] = 32'hFFFFFFFF; b[1] = 32'h00000007;
        for (int m = 0; m < 2; m++) begin
            d = mk(OP_MUL, a[m], b[m], 0, 0, 1);
            d.rd = 5'(10 + m);
            for (int c = 0; c < STEPS; c++) begin
                @(negedge clk);
                bus.from_DE_latch = d;   // DE holds the MUL while stalled
                sb.push_back((c == STEPS - 1) ? ex(d, a[m] * b[m], 32'h0) : agex_latch_t'('0));
                st = (c < STEPS - 1);
                #1;
                n_checks++;
                if (bus.from_AGEX_to_DE !== {st, d.rd, 1'b1}) begin
                    n_fail++; $display("FAIL mul%0d_de_c%0d: got %h expected %h", m, c,
                                       bus.from_AGEX_to_DE, {st, d.rd, 1'b1});
                end
                @(posedge clk); #1;
                e = sb.pop_front();
                n_checks++;
                if (bus.AGEX_latch_out !== e) begin
                    n_fail++; $display("FAIL mul%0d_latch_e%0d: got %h expected %h", m, c,
                                       bus.AGEX_latch_out, e);
                end
            end
        end
        @(negedge clk);
        bus.from_DE_latch = '0;
        sb.push_back('0);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.AGEX_latch_out !== e) begin
            n_fail++; $display("FAIL mul_after_latch: got %h expected %h", bus.AGEX_latch_out, e);
        end
    endtask

    task automatic test_mul_reset();
        de_latch_t   d;
        agex_latch_t e;
        d = mk(OP_MUL, 32'h1234, 32'h5678, 0, 0, 1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.from_DE_latch = d;
            sb.push_back('0);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (bus.AGEX_latch_out !== e) begin
                n_fail++; $display("FAIL mrst_latch_c%0d: got %h expected %h", c, bus.AGEX_latch_out, e);
            end
        end
        // now in BUSY step 2
        @(negedge clk);
        reset = 1'b1;
        sb.push_back('0);
        #1;
        n_checks++;
        if (bus.from_AGEX_to_DE !== {1'b0, 5'd5, 1'b0}) begin
            n_fail++; $display("FAIL mrst_de_in_reset: got %h expected %h", bus.from_AGEX_to_DE, {1'b0, 5'd5, 1'b0});
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.AGEX_latch_out !== e) begin
            n_fail++; $display("FAIL mrst_latch_reset: got %h expected %h", bus.AGEX_latch_out, e);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.from_DE_latch = '0;
        for (int c = 0; c < STEPS; c++) begin
            sb.push_back('0);
            #1;
            n_checks++;
            if (bus.from_AGEX_to_DE[6] !== 1'b0) begin
                n_fail++; $display("FAIL mrst_stall_c%0d: got %b expected 0", c, bus.from_AGEX_to_DE[6]);
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (bus.AGEX_latch_out !== e) begin
                n_fail++; $display("FAIL mrst_no_product_c%0d: got %h expected %h", c, bus.AGEX_latch_out, e);
            end
            @(negedge clk);
        end
        d = mk(OP_ADDI, 32'h10, 0, 32'h5, 0, 1);
        bus.from_DE_latch = d;
        sb.push_back(ex(d, 32'h15, 32'h0));
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.AGEX_latch_out !== e) begin
            n_fail++; $display("FAIL mrst_resume: got %h expected %h", bus.AGEX_latch_out, e);
        end
        @(negedge clk);
        bus.from_DE_latch = '0;
    endtask

    initial begin
        bus.from_DE_latch = '0;
        test_reset();
        test_alu();
        test_branch();
        test_back_to_back_mul();
        test_mul_reset();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
